// File: rtl/mux21_pkg.sv
// mux21_pkg: shared types and constants for the mux21_sw select controller.
package mux21_pkg;
   typedef enum logic [1:0] {IDLE, G1, G2, DEAD} state_t;
   localparam logic SEL_IN1 = 1'b0;
   localparam logic SEL_IN2 = 1'b1;
   localparam int HOLD_DEF = 4;
   function automatic state_t g_of(input logic sel);
      return (sel == SEL_IN2) ? G2 : G1;
   endfunction
endpackage

// File: rtl/mux21_hold_cnt.sv
// mux21_hold_cnt: grant-length counter; tc marks the last permitted cycle, then wraps to 0.
module mux21_hold_cnt #(
   parameter int HOLD = 4,
   localparam int CW = $clog2(HOLD)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      tc = cnt_q == CW'(HOLD - 1);
      cnt_d = (clr | (en & tc)) ? '0 : en ? cnt_q + CW'(1) : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/mux21_sel_arb.sv
// mux21_sel_arb: round-robin select for mux21_sw with bounded hold and a one-cycle
// dead time on every ctrl flip, so ctrl never moves while or as vld rises.
module mux21_sel_arb import mux21_pkg::*; #(
   parameter int HOLD = HOLD_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic req1,
   input  logic req2,
   output logic ctrl,
   output logic gnt1,
   output logic gnt2,
   output logic vld
);
   state_t state_q, state_d;
   logic ctrl_q, ctrl_d, last_q, last_d;
   logic win, own, oth, tc, in_g;
   mux21_hold_cnt #(.HOLD(HOLD)) u_cnt (
      .clk(clk),
      .rst(rst),
      .clr(state_d != state_q),
      .en(in_g),
      .tc(tc)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ctrl_q  <= SEL_IN1;
         last_q  <= SEL_IN2;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         last_q  <= last_d;
      end
   end
   always_comb begin
      state_d = state_q;
      ctrl_d = ctrl_q;
      in_g = (state_q == G1) | (state_q == G2);
      win = (req1 & req2) ? ~last_q : req2;
      own = (state_q == G1) ? req1 : req2;
      oth = (state_q == G1) ? req2 : req1;
      case (state_q)
         IDLE: if (req1 | req2) begin
            state_d = (win == ctrl_q) ? g_of(win) : DEAD;
            ctrl_d = win;
         end
         G1, G2: if (oth & (~own | tc)) begin
            state_d = DEAD;
            ctrl_d = ~ctrl_q;
         end else if (~own) state_d = IDLE;
         DEAD: state_d = ((ctrl_q == SEL_IN2) ? req2 : req1) ? g_of(ctrl_q) : IDLE;
         default: state_d = IDLE;
      endcase
      // round-robin memory follows whichever side was last granted
      last_d = ((state_d == G1 || state_d == G2) && state_d != state_q) ? (state_d == G2) : last_q;
   end
   always_comb begin
      ctrl = ctrl_q;
      gnt1 = state_q == G1;
      gnt2 = state_q == G2;
      vld = gnt1 | gnt2;
   end
endmodule

// File: tb/tb_mux21_sel_arb.sv
// tb_mux21_sel_arb: directed checks of mux21_sel_arb with HOLD=4; observed vector is {ctrl,gnt1,gnt2,vld}.
module tb_mux21_sel_arb;
   logic clk = 1'b0, rst = 1'b1, req1 = 1'b0, req2 = 1'b0;
   logic ctrl, gnt1, gnt2, vld;
   int checks = 0, failures = 0;
   localparam logic [3:0] S_IDLE0 = 4'b0000, S_G1 = 4'b0101, S_DEAD1 = 4'b1000,
                          S_DEAD0 = 4'b0000, S_G2 = 4'b1011, S_IDLE1 = 4'b1000;
   mux21_sel_arb #(.HOLD(4)) dut (
      .clk(clk), .rst(rst), .req1(req1), .req2(req2),
      .ctrl(ctrl), .gnt1(gnt1), .gnt2(gnt2), .vld(vld)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [3:0] exp);
      logic [3:0] obs;
      obs = {ctrl, gnt1, gnt2, vld};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
         $error("%s", tag);
      end
   endtask
   task automatic do_rst();
      rst = 1'b1; req1 = 1'b0; req2 = 1'b0;
      tick();
      rst = 1'b0;
   endtask
   initial begin
      logic prev;
      int k;
      do_rst();
      chk("reset", S_IDLE0);
      // req1 alone for 3 cycles, no ctrl flip needed
      req1 = 1'b1;
      tick(); chk("r1_c1", S_G1);
      tick(); chk("r1_c2", S_G1);
      tick(); chk("r1_c3", S_G1);
      req1 = 1'b0;
      tick(); chk("r1_release", S_IDLE0);
      // req2 alone needs a flip: DEAD then G2
      do_rst();
      req2 = 1'b1;
      tick(); chk("r2_dead", S_DEAD1);
      tick(); chk("r2_gnt", S_G2);
      req2 = 1'b0;
      tick(); chk("r2_idle", S_IDLE1);
      // tie with last=2 and ctrl=1: in1 wins through DEAD
      req1 = 1'b1; req2 = 1'b1;
      tick(); chk("tie_l2_dead", S_DEAD0);
      tick(); chk("tie_l2_g1", S_G1);
      req1 = 1'b0; req2 = 1'b0;
      tick(); chk("tie_l2_idle", S_IDLE0);
      // tie with last=1 and ctrl=0: in2 wins through DEAD
      req1 = 1'b1; req2 = 1'b1;
      tick(); chk("tie_l1_dead", S_DEAD1);
      tick(); chk("tie_l1_g2", S_G2);
      req1 = 1'b0; req2 = 1'b0;
      tick(); chk("tie_l1_idle", S_IDLE1);
      // continuous conflict: G1x4, DEAD, G2x4, DEAD, repeating
      do_rst();
      req1 = 1'b1; req2 = 1'b1;
      prev = ctrl;
      for (int c = 1; c <= 20; c++) begin
         tick();
         k = (c - 1) % 10;
         chk($sformatf("rr_c%0d", c), {k >= 4 && k < 9, k < 4, k >= 5 && k < 9, k < 4 || (k >= 5 && k < 9)});
         if (ctrl !== prev) begin
            checks++;
            assert (vld === 1'b0) else begin
               failures++;
               $display("FAIL rr_flip_vld_c%0d observed=%b expected=0", c, vld);
               $error("rr_flip_vld");
            end
         end
         prev = ctrl;
      end
      // lone requester keeps grant across the counter wrap, then is preempted at tc
      do_rst();
      req1 = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick(); chk($sformatf("wrap_c%0d", c), S_G1);
      end
      req2 = 1'b1;
      tick(); chk("wrap_cnt2", S_G1);
      tick(); chk("wrap_cnt3", S_G1);
      tick(); chk("wrap_preempt", S_DEAD1);
      tick(); chk("wrap_g2", S_G2);
      // G2 at cnt=2: req2 drops while req1 rises
      do_rst();
      req2 = 1'b1;
      tick(); chk("swap_dead1", S_DEAD1);
      tick(); chk("swap_cnt0", S_G2);
      tick(); chk("swap_cnt1", S_G2);
      tick(); chk("swap_cnt2", S_G2);
      req2 = 1'b0; req1 = 1'b1;
      tick(); chk("swap_dead0", S_DEAD0);
      tick(); chk("swap_g1", S_G1);
      // reset in the middle of G2 with req1 pending
      do_rst();
      req2 = 1'b1;
      tick(); chk("mrst_dead", S_DEAD1);
      tick(); chk("mrst_g2", S_G2);
      rst = 1'b1; req1 = 1'b1;
      tick(); chk("mrst_idle", S_IDLE0);
      rst = 1'b0; req2 = 1'b0;
      tick(); chk("mrst_g1", S_G1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
